// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared types and constants for the Ascon decryption absorb path
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CT,
    OUT,
    PERM,
    WAIT_PERM,
    DONE
  } type_dec_fsm;

  localparam logic [7:0] PAD_BYTE = 8'h80;

endpackage

// File: rtl/dec_pad_mask.sv
// rtl/dec_pad_mask.sv - byte mask (top n bytes) and pad word for the final ciphertext block
module dec_pad_mask
  import ascon_pack::*;
(
  input  logic [2:0]  valid_bytes,
  output logic [63:0] mask,
  output logic [63:0] pad
);

  logic [5:0] shamt;

  assign shamt = {valid_bytes, 3'b000};
  assign mask  = ~({64{1'b1}} >> shamt);
  assign pad   = {PAD_BYTE, 56'd0} >> shamt;

endmodule

// File: rtl/cipher_absorb_dec.sv
// rtl/cipher_absorb_dec.sv - Ascon decryption data-phase absorb FSM; DEC_BLOCK_CNT_EN adds a block counter
module cipher_absorb_dec
  import ascon_pack::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [63:0]      cipher_i,
  input  logic             cipher_valid_i,
  output logic             cipher_ready_o,
  input  logic             last_i,
  input  logic [2:0]       valid_bytes_i,
  input  type_state        state_i,
  output type_state        state_o,
  output logic             state_we_o,
  output logic             perm_start_o,
  input  logic             perm_done_i,
  output logic [63:0]      plain_o,
  output logic [3:0]       plain_bytes_o,
  output logic             plain_valid_o,
  input  logic             plain_ready_i,
  output logic             done_o,
  output logic [CNT_W-1:0] block_cnt_o
);

  type_dec_fsm fsm;
  logic        last_q;
  logic [63:0] mask;
  logic [63:0] pad;
  logic [63:0] pt_word;
  logic [63:0] ct_word;
  logic [3:0]  pt_bytes;

  dec_pad_mask u_pad_mask (
    .valid_bytes (valid_bytes_i),
    .mask        (mask),
    .pad         (pad)
  );

  // Final block: keep ciphertext bytes in the rate, padded plaintext-xor-state elsewhere
  always_comb begin
    pt_word  = state_i[0] ^ cipher_i;
    ct_word  = cipher_i;
    pt_bytes = 4'd8;
    if (last_i) begin
      pt_word  = (state_i[0] ^ cipher_i) & mask;
      ct_word  = (cipher_i & mask) | ((state_i[0] ^ pad) & ~mask);
      pt_bytes = {1'b0, valid_bytes_i};
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm            <= IDLE;
      last_q         <= 1'b0;
      state_o        <= '0;
      state_we_o     <= 1'b0;
      perm_start_o   <= 1'b0;
      plain_o        <= '0;
      plain_bytes_o  <= '0;
      plain_valid_o  <= 1'b0;
      cipher_ready_o <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state_we_o   <= 1'b0;
      perm_start_o <= 1'b0;
      done_o       <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start_i) begin
            fsm            <= WAIT_CT;
            cipher_ready_o <= 1'b1;
          end
        end
        WAIT_CT: begin
          if (cipher_valid_i) begin
            state_o        <= {state_i[4:1], ct_word};
            state_we_o     <= 1'b1;
            plain_o        <= pt_word;
            plain_bytes_o  <= pt_bytes;
            last_q         <= last_i;
            cipher_ready_o <= 1'b0;
            plain_valid_o  <= 1'b1;
            fsm            <= OUT;
          end
        end
        OUT: begin
          if (plain_ready_i) begin
            plain_valid_o <= 1'b0;
            if (last_q) begin
              done_o <= 1'b1;
              fsm    <= DONE;
            end else begin
              perm_start_o <= 1'b1;
              fsm          <= PERM;
            end
          end
        end
        PERM: fsm <= WAIT_PERM;
        WAIT_PERM: begin
          if (perm_done_i) begin
            cipher_ready_o <= 1'b1;
            fsm            <= WAIT_CT;
          end
        end
        DONE: fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef DEC_BLOCK_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (fsm == IDLE && start_i) begin
      cnt_q <= '0;
    end else if (fsm == WAIT_CT && cipher_valid_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign block_cnt_o = cnt_q;
`else
  assign block_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cipher_absorb_dec.sv
// tb/tb_cipher_absorb_dec.sv - scoreboard bench for cipher_absorb_dec
module tb_cipher_absorb_dec;
  import ascon_pack::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start_i = 1'b0;
  logic [63:0]      cipher_i = '0;
  logic             cipher_valid_i = 1'b0;
  logic             cipher_ready_o;
  logic             last_i = 1'b0;
  logic [2:0]       valid_bytes_i = '0;
  type_state        state_i = '0;
  type_state        state_o;
  logic             state_we_o;
  logic             perm_start_o;
  logic             perm_done_i = 1'b0;
  logic [63:0]      plain_o;
  logic [3:0]       plain_bytes_o;
  logic             plain_valid_o;
  logic             plain_ready_i = 1'b1;
  logic             done_o;
  logic [CNT_W-1:0] block_cnt_o;

  cipher_absorb_dec #(.CNT_W(CNT_W)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start_i),
    .cipher_i       (cipher_i),
    .cipher_valid_i (cipher_valid_i),
    .cipher_ready_o (cipher_ready_o),
    .last_i         (last_i),
    .valid_bytes_i  (valid_bytes_i),
    .state_i        (state_i),
    .state_o        (state_o),
    .state_we_o     (state_we_o),
    .perm_start_o   (perm_start_o),
    .perm_done_i    (perm_done_i),
    .plain_o        (plain_o),
    .plain_bytes_o  (plain_bytes_o),
    .plain_valid_o  (plain_valid_o),
    .plain_ready_i  (plain_ready_i),
    .done_o         (done_o),
    .block_cnt_o    (block_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] plain;
    logic [3:0]  bytes;
    type_state   st;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  int   perm_cnt = 0;
  int   done_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_model(input type_state s, input logic [63:0] c,
                                     input logic last, input logic [2:0] n);
    exp_t        r;
    logic [63:0] m;
    logic [63:0] p;
    m = '0;
    p = '0;
    r.st = s;
    if (!last) begin
      r.plain = s[0] ^ c;
      r.bytes = 4'd8;
      r.st[0] = c;
    end else begin
      for (int b = 0; b < 8; b++)
        if (b < int'(n)) m[63-8*b -: 8] = 8'hFF;
      p[63-8*int'(n) -: 8] = 8'h80;
      r.plain = (s[0] ^ c) & m;
      r.bytes = {1'b0, n};
      r.st[0] = (c & m) | ((s[0] ^ p) & ~m);
    end
    return r;
  endfunction

  // Scoreboard: pop on every plaintext handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (state_we_o) we_cnt++;
      if (perm_start_o) perm_cnt++;
      if (done_o) done_cnt++;
      if (plain_valid_o && plain_ready_i) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("plain_o", plain_o, mon_e.plain);
          check_val("plain_bytes_o", 64'(plain_bytes_o), 64'(mon_e.bytes));
          for (int w = 0; w < 5; w++)
            check_val($sformatf("state_o_w%0d", w), state_o[w], mon_e.st[w]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_block(input type_state s, input logic [63:0] c,
                            input logic last, input logic [2:0] n);
    bit ok;
    ok = 0;
    state_i        = s;
    cipher_i       = c;
    last_i         = last;
    valid_bytes_i  = n;
    cipher_valid_i = 1'b1;
    sb_q.push_back(ref_model(s, c, last, n));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cipher_ready_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_val("ct_accept_timeout", 0, 1);
    tick();
    cipher_valid_i = 1'b0;
  endtask

  task automatic wait_perm_cycle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (perm_start_o) begin
        ok = 1;
        break;
      end
    end
    check_val("perm_start_seen", 64'(ok), 1);
    check_val("perm_after_plain_hs", 64'(sb_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
    perm_done_i = 1'b1;
    tick();
    perm_done_i = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1;
        break;
      end
    end
    check_val("done_seen", 64'(ok), 1);
    tick();
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_val({pfx, "_cipher_ready"}, 64'(cipher_ready_o), 0);
    check_val({pfx, "_plain_valid"}, 64'(plain_valid_o), 0);
    check_val({pfx, "_plain_o"}, plain_o, 0);
    check_val({pfx, "_plain_bytes"}, 64'(plain_bytes_o), 0);
    check_val({pfx, "_state_we"}, 64'(state_we_o), 0);
    check_val({pfx, "_perm_start"}, 64'(perm_start_o), 0);
    check_val({pfx, "_done"}, 64'(done_o), 0);
    check_val({pfx, "_block_cnt"}, 64'(block_cnt_o), 0);
    for (int w = 0; w < 5; w++)
      check_val($sformatf("%s_state_w%0d", pfx, w), state_o[w], 0);
  endtask

  function automatic type_state rand_state(input logic [63:0] w0);
    type_state s;
    for (int w = 1; w < 5; w++) s[w] = {$urandom, $urandom};
    s[0] = w0;
    return s;
  endfunction

  initial begin
    int we0;
    int perm0;
    int done0;
    logic [63:0] exp_plain;
    exp_t e;

    #2 rst = 1'b1;
    #3;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Full block
    we0 = we_cnt; perm0 = perm_cnt;
    do_start();
    send_block(rand_state(64'h0123456789ABCDEF), 64'hFFFFFFFFFFFFFFFF, 1'b0, 3'd0);
    wait_perm_cycle();
    check_val("full_we_pulses", 64'(we_cnt - we0), 1);
    check_val("full_perm_pulses", 64'(perm_cnt - perm0), 1);

    // Partial final block
    perm0 = perm_cnt; done0 = done_cnt;
    send_block(rand_state(64'h1111111111111111), 64'hAABBCC0000000000, 1'b1, 3'd3);
    wait_done();
    check_val("partial_done_pulses", 64'(done_cnt - done0), 1);
    check_val("partial_no_perm", 64'(perm_cnt - perm0), 0);

    // Pad-only final block
    do_start();
    send_block(rand_state(64'h0), 64'h0123456789ABCDEF, 1'b1, 3'd0);
    wait_done();

    // Backpressure on plaintext
    plain_ready_i = 1'b0;
    perm0 = perm_cnt;
    do_start();
    send_block(rand_state(64'h5A5A5A5A5A5A5A5A), 64'h0F0F0F0F0F0F0F0F, 1'b0, 3'd0);
    e = ref_model(state_i, cipher_i, 1'b0, 3'd0);
    exp_plain = e.plain;
    repeat (5) begin
      @(negedge clk);
      check_val("bp_plain_valid", 64'(plain_valid_o), 1);
      check_val("bp_plain_stable", plain_o, exp_plain);
      check_val("bp_cipher_ready", 64'(cipher_ready_o), 0);
      check_val("bp_no_perm", 64'(perm_start_o), 0);
    end
    check_val("bp_perm_count", 64'(perm_cnt - perm0), 0);
    @(posedge clk);
    #1 plain_ready_i = 1'b1;
    wait_perm_cycle();
    send_block(rand_state({$urandom, $urandom}), {$urandom, $urandom}, 1'b1, 3'd7);
    wait_done();

    // Asynchronous reset while waiting on the permutation
    do_start();
    send_block(rand_state({$urandom, $urandom}), {$urandom, $urandom}, 1'b0, 3'd0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (perm_start_o) break;
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_idle_outputs("rst_wait_perm");
    @(negedge clk);
    rst = 1'b0;
    perm0 = perm_cnt; we0 = we_cnt; done0 = done_cnt;
    repeat (3) tick();
    check_val("post_rst_no_perm", 64'(perm_cnt - perm0), 0);
    check_val("post_rst_no_we", 64'(we_cnt - we0), 0);
    check_val("post_rst_no_done", 64'(done_cnt - done0), 0);
    do_start();
    send_block(rand_state({$urandom, $urandom}), {$urandom, $urandom}, 1'b1, 3'd4);
    wait_done();

    // Three blocks, last on the third
    do_start();
    send_block(rand_state({$urandom, $urandom}), {$urandom, $urandom}, 1'b0, 3'd0);
    wait_perm_cycle();
    send_block(rand_state({$urandom, $urandom}), {$urandom, $urandom}, 1'b0, 3'd0);
    wait_perm_cycle();
    send_block(rand_state({$urandom, $urandom}), {$urandom, $urandom}, 1'b1, 3'd5);
    wait_done();
`ifdef DEC_BLOCK_CNT_EN
    check_val("block_cnt_three", 64'(block_cnt_o), 3);
`else
    check_val("block_cnt_three", 64'(block_cnt_o), 0);
`endif

    // Random final blocks across all byte counts
    for (int k = 0; k < 8; k++) begin
      do_start();
      send_block(rand_state({$urandom, $urandom}), {$urandom, $urandom}, 1'b1, 3'(k));
      wait_done();
    end

    check_val("sb_empty_at_end", 64'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
